// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer:
// opcodes, widths and the sequencer state encoding.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command / response / ALU bundle for the sequencer.
// master = requester plus ALU model, slave = sequencer.
interface alu_cmd_sequencer_if
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [TAG_W-1:0]  cmd_tag;

  logic [OP_W-1:0]   alu_ctrl;
  logic [DATA_W-1:0] alu_data0;
  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic [CNT_W-1:0]  ops_count;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    output rsp_ready, alu_result,
    input  cmd_ready, alu_ctrl, alu_data0, alu_data1,
    input  rsp_valid, rsp_result, rsp_tag, rsp_err, ops_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  rsp_ready, alu_result,
    output cmd_ready, alu_ctrl, alu_data0, alu_data1,
    output rsp_valid, rsp_result, rsp_tag, rsp_err, ops_count
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences one command at a time through an external
// combinational ALU and returns a tagged, error-checked response.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [TAG_W-1:0]  cmd_tag_i,
  output logic [OP_W-1:0]   alu_ctrl_o,
  output logic [DATA_W-1:0] alu_data0_o,
  output logic [DATA_W-1:0] alu_data1_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              rsp_err_o,
  output logic [CNT_W-1:0]  ops_count_o
);

  state_t           state;
  logic [TAG_W-1:0] tag_q;
  logic             err;

  function automatic logic op_err(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] b
  );
    logic is_div;
    is_div = (op == OP_DIV) || (op == OP_MOD);
    return (op > OP_MOD) || (is_div && (b == '0));
  endfunction

  // Operands are already registered on the ALU ports, so check those.
  assign err = op_err(alu_ctrl_o, alu_data1_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cmd_ready_o  <= 1'b1;
      alu_ctrl_o   <= '0;
      alu_data0_o  <= '0;
      alu_data1_o  <= '0;
      tag_q        <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_tag_o    <= '0;
      rsp_err_o    <= 1'b0;
      ops_count_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            state       <= DRIVE;
            cmd_ready_o <= 1'b0;
            alu_ctrl_o  <= cmd_op_i;
            alu_data0_o <= cmd_a_i;
            alu_data1_o <= cmd_b_i;
            tag_q       <= cmd_tag_i;
          end
        end
        DRIVE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state        <= RESP;
          rsp_valid_o  <= 1'b1;
          rsp_err_o    <= err;
          rsp_result_o <= err ? '0 : alu_result_i;
          rsp_tag_o    <= tag_q;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            ops_count_o <= ops_count_o + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural
// ALU model hung off the shared bus interface.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  alu_cmd_sequencer #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (bus.cmd_valid),
    .cmd_ready_o  (bus.cmd_ready),
    .cmd_op_i     (bus.cmd_op),
    .cmd_a_i      (bus.cmd_a),
    .cmd_b_i      (bus.cmd_b),
    .cmd_tag_i    (bus.cmd_tag),
    .alu_ctrl_o   (bus.alu_ctrl),
    .alu_data0_o  (bus.alu_data0),
    .alu_data1_o  (bus.alu_data1),
    .alu_result_i (bus.alu_result),
    .rsp_valid_o  (bus.rsp_valid),
    .rsp_ready_i  (bus.rsp_ready),
    .rsp_result_o (bus.rsp_result),
    .rsp_tag_o    (bus.rsp_tag),
    .rsp_err_o    (bus.rsp_err),
    .ops_count_o  (bus.ops_count)
  );

  // Stand-in for alu_top; odd patterns on illegal/zero-divisor cases
  // make sure the sequencer really forces the result to zero.
  always_comb begin
    bus.alu_result = 8'hA5;
    case (bus.alu_ctrl)
      3'b000: bus.alu_result = bus.alu_data0 + bus.alu_data1;
      3'b001: bus.alu_result = bus.alu_data0 - bus.alu_data1;
      3'b010: bus.alu_result = bus.alu_data0 * bus.alu_data1;
      3'b011: bus.alu_result = (bus.alu_data1 == 0) ? 8'hFF
                             : bus.alu_data0 / bus.alu_data1;
      3'b100: bus.alu_result = (bus.alu_data1 == 0) ? 8'hFF
                             : bus.alu_data0 % bus.alu_data1;
      default: bus.alu_result = 8'hA5;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command from IDLE and wait (bounded) for rsp_valid.
  task automatic send(input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] tag,
                      output int lat);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    step();
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic take();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
  endtask

  task automatic check_resp(input string name, input int lat,
                            input logic [7:0] res, input logic [3:0] tag,
                            input logic err);
    n_tests++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL %s latency got %0d want 3", name, lat);
    end
    n_tests++;
    if (bus.rsp_result !== res || bus.rsp_tag !== tag
        || bus.rsp_err !== err) begin
      n_fail++;
      $display("FAIL %s rsp got res=%0d tag=%0d err=%b want res=%0d tag=%0d err=%b",
               name, bus.rsp_result, bus.rsp_tag, bus.rsp_err, res, tag, err);
    end
  endtask

  task automatic check_count(input string name);
    n_tests++;
    if (bus.ops_count !== exp_count[7:0]) begin
      n_fail++;
      $display("FAIL %s ops_count got %0d want %0d",
               name, bus.ops_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_count = 0;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0
        || bus.rsp_result !== 8'h00 || bus.rsp_tag !== 4'h0
        || bus.rsp_err !== 1'b0 || bus.alu_ctrl !== 3'b000
        || bus.alu_data0 !== 8'h00 || bus.alu_data1 !== 8'h00
        || bus.ops_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset got rdy=%b vld=%b res=%h tag=%h err=%b ctrl=%b d0=%h d1=%h cnt=%h want rdy=1 rest 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_tag,
               bus.rsp_err, bus.alu_ctrl, bus.alu_data0, bus.alu_data1,
               bus.ops_count);
    end
  endtask

  task automatic test_add();
    int lat;
    send(3'b000, 8'd200, 8'd100, 4'd5, lat);
    check_resp("add", lat, 8'd44, 4'd5, 1'b0);
    take();
    check_count("add_count");
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || bus.alu_ctrl !== 3'b000
        || bus.alu_data0 !== 8'd200 || bus.alu_data1 !== 8'd100) begin
      n_fail++;
      $display("FAIL add_idle_hold got rdy=%b ctrl=%b d0=%0d d1=%0d want 1 000 200 100",
               bus.cmd_ready, bus.alu_ctrl, bus.alu_data0, bus.alu_data1);
    end
  endtask

  task automatic test_sub_mul();
    int lat;
    send(3'b001, 8'd5, 8'd7, 4'd1, lat);
    check_resp("sub", lat, 8'd254, 4'd1, 1'b0);
    take();
    send(3'b010, 8'd16, 8'd20, 4'd2, lat);
    check_resp("mul", lat, 8'd64, 4'd2, 1'b0);
    take();
    check_count("mul_count");
  endtask

  task automatic test_div_zero();
    int lat;
    send(3'b011, 8'd9, 8'd0, 4'd3, lat);
    check_resp("div0", lat, 8'h00, 4'd3, 1'b1);
    take();
    check_count("div0_count");
  endtask

  task automatic test_illegal_mod();
    int lat;
    send(3'b111, 8'd1, 8'd1, 4'd7, lat);
    check_resp("illegal", lat, 8'h00, 4'd7, 1'b1);
    take();
    send(3'b100, 8'd17, 8'd5, 4'd8, lat);
    check_resp("mod", lat, 8'd2, 4'd8, 1'b0);
    take();
    send(3'b100, 8'd17, 8'd0, 4'd9, lat);
    check_resp("mod0", lat, 8'h00, 4'd9, 1'b1);
    take();
    check_count("mod_count");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] r0;
    logic [3:0] t0;
    logic       e0;
    send(3'b000, 8'd10, 8'd20, 4'd11, lat);
    check_resp("bp", lat, 8'd30, 4'd11, 1'b0);
    r0 = bus.rsp_result;
    t0 = bus.rsp_tag;
    e0 = bus.rsp_err;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b001;
    bus.cmd_tag   = 4'd12;
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0
          || bus.rsp_result !== r0 || bus.rsp_tag !== t0
          || bus.rsp_err !== e0 || bus.alu_ctrl !== 3'b000) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b res=%0d tag=%0d want 1 0 %0d %0d",
                 i, bus.rsp_valid, bus.cmd_ready, bus.rsp_result,
                 bus.rsp_tag, r0, t0);
      end
    end
    bus.cmd_valid = 1'b0;
    take();
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0",
               bus.cmd_ready, bus.rsp_valid);
    end
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_not_queued got vld=%b rdy=%b want 0 1",
               bus.rsp_valid, bus.cmd_ready);
    end
    check_count("bp_count");
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 8'd3;
    bus.cmd_b     = 8'd4;
    bus.cmd_tag   = 4'd6;
    step();
    bus.cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    exp_count = 0;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0
        || bus.rsp_result !== 8'h00 || bus.rsp_tag !== 4'h0
        || bus.rsp_err !== 1'b0 || bus.alu_ctrl !== 3'b000
        || bus.alu_data0 !== 8'h00 || bus.alu_data1 !== 8'h00
        || bus.ops_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid got rdy=%b vld=%b res=%h tag=%h d0=%h cnt=%h want rdy=1 rest 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_tag,
               bus.alu_data0, bus.ops_count);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_no_rsp cyc %0d got vld=%b want 0",
                 i, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] a;
    logic [7:0] sum;
    logic [3:0] tag;
    int bad = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a   = 8'(i);
      sum = 8'(i + 1);
      tag = 4'(i);
      send(3'b000, a, 8'd1, tag, lat);
      n_tests++;
      if (lat !== 3 || bus.rsp_tag !== tag || bus.rsp_result !== sum
          || bus.rsp_err !== 1'b0 || bus.ops_count !== a) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL b2b #%0d got lat=%0d tag=%0d res=%0d cnt=%0d want 3 %0d %0d %0d",
                   i, lat, bus.rsp_tag, bus.rsp_result, bus.ops_count,
                   tag, sum, a);
      end
      step();
    end
    bus.rsp_ready = 1'b0;
    n_tests++;
    if (bus.ops_count !== 8'h00 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap got cnt=%0d rdy=%b want 0 1",
               bus.ops_count, bus.cmd_ready);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.cmd_tag   = 4'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_mul();
    test_div_zero();
    test_illegal_mod();
    test_backpressure();
    test_reset_mid();
    test_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
